// File: rtl/reg_window_pkg.sv
// Shared constants for the windowed register-file frame-pointer controller:
// FSM state encoding, fault codes and the derived frame-pointer ceiling.
package reg_window_pkg;

    // Default register-file geometry
    localparam int DEF_PHYS_REGS = 16;
    localparam int DEF_WIN_REGS  = 8;

    // Highest legal frame pointer: the window must fit entirely in the file
    function automatic int fp_max(input int phys_regs, input int win_regs);
        return phys_regs - win_regs;
    endfunction

    localparam int FP_MAX = fp_max(DEF_PHYS_REGS, DEF_WIN_REGS);

    // Controller states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVE   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    // Fault codes reported on Fault_Code
    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OVF  = 2'd1;
    localparam logic [1:0] FC_UNF  = 2'd2;
    localparam logic [1:0] FC_ILL  = 2'd3;

endpackage : reg_window_pkg

// File: rtl/offset_lifo.sv
// LIFO of CALL window offsets. The top entry is presented combinationally so
// an RTN can compute its target in the same cycle it pops.
module offset_lifo
    import reg_window_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_wr_idx  = r_count[AW-1:0];
    assign w_top_idx = r_count[AW-1:0] - AW'(1);
    assign o_data    = r_mem[w_top_idx];

    // Guard against pushing a full stack or popping an empty one
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty && !i_push;

    // Occupancy counter: +1 on push, -1 on pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage array written on push
    // NOTE: the storage is deliberately left out of reset; entries above the
    // count are never read, so clearing them would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule : offset_lifo

// File: rtl/reg_window_ctrl.sv
// Frame-pointer controller for a windowed register file. Accepts CALL/RTN
// from the decoder, moves the window with a one-cycle strobe followed by a
// settle cycle, and remembers CALL offsets so each RTN restores the exact
// previous window. Illegal, overflowing and underflowing requests park the
// controller in a sticky FAULT state until Fault_Clr.
module reg_window_ctrl
    import reg_window_pkg::*;
#(
    parameter int PHYS_REGS   = DEF_PHYS_REGS,
    parameter int WIN_REGS    = DEF_WIN_REGS,
    parameter int STACK_DEPTH = 8,
    parameter int FP_W        = 4
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            Call_Req,
    input  logic            Rtn_Req,
    input  logic [2:0]      Offset,
    input  logic            Fault_Clr,
    output logic            Req_Ready,
    output logic [FP_W-1:0] New_FP,
    output logic            FP_move,
    output logic            FP_push_up,
    output logic            Stall,
    output logic            Fault,
    output logic [1:0]      Fault_Code,
    output logic [3:0]      Depth
);

    localparam int FP_LIMIT = fp_max(PHYS_REGS, WIN_REGS);

    // Registered state
    logic [1:0]      r_state;
    logic [FP_W-1:0] r_fp;
    logic [FP_W-1:0] r_target;
    logic            r_push_up;
    logic [1:0]      r_fault_code;

    // Request decode
    logic [FP_W:0]   w_call_sum;
    logic [FP_W-1:0] w_rtn_fp;
    logic [2:0]      w_pop_data;
    logic            w_full;
    logic            w_empty;
    logic            w_idle;
    logic            w_accept_call;
    logic            w_accept_rtn;
    logic            w_fault_req;
    logic [1:0]      w_fault_code;
    logic            w_push;
    logic            w_pop;

    assign w_idle = (r_state == ST_IDLE);

    // CALL target is computed one bit wider so FP+Offset cannot wrap
    assign w_call_sum = {1'b0, r_fp} + (FP_W+1)'(Offset);
    assign w_rtn_fp   = r_fp - FP_W'(w_pop_data);

    // Classify the presented request; only acted on while idle
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the if/else tree leaves it unassigned and infers a latch.
        w_accept_call = 1'b0;
        w_accept_rtn  = 1'b0;
        w_fault_req   = 1'b0;
        w_fault_code  = FC_NONE;
        if (Call_Req && Rtn_Req) begin
            w_fault_req  = 1'b1;
            w_fault_code = FC_ILL;
        end else if (Call_Req) begin
            if (Offset == 3'd0) begin
                w_fault_req  = 1'b1;
                w_fault_code = FC_ILL;
            end else if (w_call_sum > (FP_W+1)'(FP_LIMIT)) begin
                w_fault_req  = 1'b1;
                w_fault_code = FC_OVF;
            end else if (w_full) begin
                w_fault_req  = 1'b1;
                w_fault_code = FC_OVF;
            end else begin
                w_accept_call = 1'b1;
            end
        end else if (Rtn_Req) begin
            if (w_empty) begin
                w_fault_req  = 1'b1;
                w_fault_code = FC_UNF;
            end else begin
                w_accept_rtn = 1'b1;
            end
        end
    end

    assign w_push = w_idle && w_accept_call;
    assign w_pop  = w_idle && w_accept_rtn;

    offset_lifo #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (3),
        .CNT_W  (4)
    ) u_offset_lifo (
        .i_clk   (Clock),
        .i_rst_n (Reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (Offset),
        .o_data  (w_pop_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (Depth)
    );

    // Controller FSM with frame-pointer, target and fault-code registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_IDLE;
            r_fp         <= '0;
            r_target     <= '0;
            r_push_up    <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_call) begin
                        r_target  <= w_call_sum[FP_W-1:0];
                        r_push_up <= 1'b1;
                        r_state   <= ST_MOVE;
                    end else if (w_accept_rtn) begin
                        r_target  <= w_rtn_fp;
                        r_push_up <= 1'b0;
                        r_state   <= ST_MOVE;
                    end else if (w_fault_req) begin
                        r_fault_code <= w_fault_code;
                        r_state      <= ST_FAULT;
                    end
                end
                ST_MOVE: begin
                    r_fp    <= r_target;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_state <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (Fault_Clr) begin
                        r_fault_code <= FC_NONE;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state
    assign Req_Ready  = w_idle;
    assign FP_move    = (r_state == ST_MOVE);
    assign Stall      = !w_idle;
    assign Fault      = (r_state == ST_FAULT);
    assign Fault_Code = r_fault_code;
    assign FP_push_up = r_push_up;
    assign New_FP     = (r_state == ST_MOVE) ? r_target : r_fp;

endmodule : reg_window_ctrl

// File: tb/tb_reg_window_ctrl.sv
// Directed self-checking bench for reg_window_ctrl. Inputs change 1 time unit
// after the rising edge and outputs are sampled there as well.
module tb_reg_window_ctrl;

    logic       Clock;
    logic       Reset_n;
    logic       Call_Req;
    logic       Rtn_Req;
    logic [2:0] Offset;
    logic       Fault_Clr;
    logic       Req_Ready;
    logic [3:0] New_FP;
    logic       FP_move;
    logic       FP_push_up;
    logic       Stall;
    logic       Fault;
    logic [1:0] Fault_Code;
    logic [3:0] Depth;

    int checks = 0;
    int errors = 0;

    reg_window_ctrl dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Call_Req   (Call_Req),
        .Rtn_Req    (Rtn_Req),
        .Offset     (Offset),
        .Fault_Clr  (Fault_Clr),
        .Req_Ready  (Req_Ready),
        .New_FP     (New_FP),
        .FP_move    (FP_move),
        .FP_push_up (FP_push_up),
        .Stall      (Stall),
        .Fault      (Fault),
        .Fault_Code (Fault_Code),
        .Depth      (Depth)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Bounded wait for the controller to become idle
    task automatic wait_ready(input string tag);
        int n = 0;
        while (Req_Ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 8'(Req_Ready), 8'd1);
    endtask

    // Present a request for one accepting cycle, then drop it
    task automatic do_req(input logic c, input logic r, input logic [2:0] off);
        Call_Req = c;
        Rtn_Req  = r;
        Offset   = off;
        tick();
        Call_Req = 1'b0;
        Rtn_Req  = 1'b0;
        Offset   = 3'd0;
    endtask

    // Full CALL/RTN with MOVE-cycle checks, ending back in IDLE
    task automatic move(input string tag, input logic is_call, input logic [2:0] off,
                        input logic [3:0] exp_fp, input logic [3:0] exp_depth);
        do_req(is_call, !is_call, off);
        check({tag, "_move"},   8'(FP_move),    8'd1);
        check({tag, "_newfp"},  8'(New_FP),     8'(exp_fp));
        check({tag, "_pushup"}, 8'(FP_push_up), 8'(is_call));
        tick();
        tick();
        check({tag, "_depth"},  8'(Depth),      8'(exp_depth));
        check({tag, "_idlefp"}, 8'(New_FP),     8'(exp_fp));
    endtask

    // Clear a fault and confirm the return to IDLE
    task automatic clear_fault(input string tag);
        Fault_Clr = 1'b1;
        tick();
        Fault_Clr = 1'b0;
        check({tag, "_clr_fault"}, 8'(Fault),      8'd0);
        check({tag, "_clr_code"},  8'(Fault_Code), 8'd0);
        check({tag, "_clr_ready"}, 8'(Req_Ready),  8'd1);
    endtask

    initial begin
        Reset_n   = 1'b0;
        Call_Req  = 1'b0;
        Rtn_Req   = 1'b0;
        Offset    = 3'd0;
        Fault_Clr = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ready",  8'(Req_Ready),  8'd1);
        check("rst_newfp",  8'(New_FP),     8'd0);
        check("rst_move",   8'(FP_move),    8'd0);
        check("rst_pushup", 8'(FP_push_up), 8'd0);
        check("rst_stall",  8'(Stall),      8'd0);
        check("rst_fault",  8'(Fault),      8'd0);
        check("rst_code",   8'(Fault_Code), 8'd0);
        check("rst_depth",  8'(Depth),      8'd0);
        Reset_n = 1'b1;
        tick();

        // CALL 3 from FP=0 with cycle-by-cycle latency
        do_req(1'b1, 1'b0, 3'd3);
        check("c3_move",   8'(FP_move),    8'd1);
        check("c3_newfp",  8'(New_FP),     8'd3);
        check("c3_pushup", 8'(FP_push_up), 8'd1);
        check("c3_stall1", 8'(Stall),      8'd1);
        check("c3_ready1", 8'(Req_Ready),  8'd0);
        check("c3_depth",  8'(Depth),      8'd1);
        tick();
        check("c3_move2",  8'(FP_move),    8'd0);
        check("c3_stall2", 8'(Stall),      8'd1);
        check("c3_ready2", 8'(Req_Ready),  8'd0);
        check("c3_newfp2", 8'(New_FP),     8'd3);
        tick();
        check("c3_ready3", 8'(Req_Ready),  8'd1);
        check("c3_stall3", 8'(Stall),      8'd0);
        check("c3_newfp3", 8'(New_FP),     8'd3);

        // CALL 5 reaches FP_MAX exactly, then unwind
        move("c5", 1'b1, 3'd5, 4'd8, 4'd2);
        move("r1", 1'b0, 3'd0, 4'd3, 4'd1);
        move("r2", 1'b0, 3'd0, 4'd0, 4'd0);

        // Reset in the middle of a MOVE with FP=5, Depth=2
        move("m2", 1'b1, 3'd2, 4'd2, 4'd1);
        move("m3", 1'b1, 3'd3, 4'd5, 4'd2);
        do_req(1'b1, 1'b0, 3'd1);
        check("mid_move",  8'(FP_move), 8'd1);
        check("mid_newfp", 8'(New_FP),  8'd6);
        Reset_n = 1'b0;
        #1;
        check("midrst_move",  8'(FP_move),   8'd0);
        check("midrst_newfp", 8'(New_FP),    8'd0);
        check("midrst_stall", 8'(Stall),     8'd0);
        check("midrst_ready", 8'(Req_Ready), 8'd1);
        check("midrst_depth", 8'(Depth),     8'd0);
        tick();
        check("midrst_move2", 8'(FP_move),   8'd0);
        Reset_n = 1'b1;
        tick();
        check("postrst_move", 8'(FP_move),   8'd0);
        check("postrst_newfp", 8'(New_FP),   8'd0);

        // Overflow: FP=6, CALL 3 -> code 1, FP unchanged; held request ignored
        move("c6", 1'b1, 3'd6, 4'd6, 4'd1);
        Call_Req = 1'b1;
        Offset   = 3'd3;
        tick();
        check("ovf_fault", 8'(Fault),      8'd1);
        check("ovf_code",  8'(Fault_Code), 8'd1);
        check("ovf_newfp", 8'(New_FP),     8'd6);
        check("ovf_move",  8'(FP_move),    8'd0);
        check("ovf_stall", 8'(Stall),      8'd1);
        check("ovf_ready", 8'(Req_Ready),  8'd0);
        tick();
        Call_Req = 1'b0;
        Offset   = 3'd0;
        check("ovf_hold",  8'(Fault),      8'd1);
        check("ovf_depth", 8'(Depth),      8'd1);
        clear_fault("ovf");
        check("ovf_fpkept", 8'(New_FP),    8'd6);
        move("r6", 1'b0, 3'd0, 4'd0, 4'd0);

        // Underflow: RTN at Depth=0
        do_req(1'b0, 1'b1, 3'd0);
        check("unf_fault", 8'(Fault),      8'd1);
        check("unf_code",  8'(Fault_Code), 8'd2);
        check("unf_depth", 8'(Depth),      8'd0);
        clear_fault("unf");

        // Illegal: CALL and RTN together
        do_req(1'b1, 1'b1, 3'd2);
        check("both_code",  8'(Fault_Code), 8'd3);
        check("both_depth", 8'(Depth),      8'd0);
        clear_fault("both");

        // Illegal: CALL with zero offset
        do_req(1'b1, 1'b0, 3'd0);
        check("zero_code",  8'(Fault_Code), 8'd3);
        check("zero_newfp", 8'(New_FP),     8'd0);
        clear_fault("zero");

        // Fill the LIFO with eight CALL 1
        for (int i = 1; i <= 8; i++) begin
            wait_ready("fill_ready");
            move("fill", 1'b1, 3'd1, 4'(i), 4'(i));
        end
        check("full_fp",    8'(New_FP), 8'd8);
        check("full_depth", 8'(Depth),  8'd8);

        // Ninth CALL overflows
        do_req(1'b1, 1'b0, 3'd1);
        check("ninth_code",  8'(Fault_Code), 8'd1);
        check("ninth_depth", 8'(Depth),      8'd8);
        check("ninth_fp",    8'(New_FP),     8'd8);
        clear_fault("ninth");

        // Eight RTNs restore FP=0
        for (int i = 7; i >= 0; i--) begin
            wait_ready("drain_ready");
            move("drain", 1'b0, 3'd0, 4'(i), 4'(i));
        end
        check("end_fp",    8'(New_FP), 8'd0);
        check("end_depth", 8'(Depth),  8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_window_ctrl
